// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width; one bit of headroom keeps DWELL=1 at a legal 1-bit counter.
  function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
    return $clog2(dwell) + 1;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle between the driving controller and scan_decoder.
interface scan_decoder_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned N_OUT = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] d;
  logic [N_OUT-1:0] y;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, load, d,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, load, d,
    output y, idx, wrap
  );
endinterface

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational select-to-one-hot decoder with selectable output polarity.
module onehot_decode #(
  parameter int unsigned SEL_W      = 2,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic [SEL_W-1:0]        i_sel,
  output logic [(1<<SEL_W)-1:0]   o_y_c
);
  localparam int unsigned N_OUT = 1 << SEL_W;

  always_comb begin
    o_y_c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      o_y_c[i] = (i_sel == SEL_W'(i)) ^ ACTIVE_LOW;
    end
  end
endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with direct (loaded select) and auto-scan modes.
// Drives row/digit select lines; y and idx are always updated together.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave bus
);
  localparam int unsigned N_OUT = 1 << SEL_W;
  localparam int unsigned CNT_W = dwell_cnt_w(DWELL);
  localparam logic [N_OUT-1:0] Y_INACTIVE = ACTIVE_LOW ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic [N_OUT-1:0] r_y;

  state_e           w_state_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic [N_OUT-1:0] w_y_nxt;
  logic [N_OUT-1:0] w_dec;

  // Decode the next index so y lands in the same cycle as idx.
  onehot_decode #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .i_sel (w_idx_nxt),
    .o_y_c (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_y     <= Y_INACTIVE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Priority: en=0 > load > dwell advance; a mode change applies on the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;

    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (bus.mode == MODE_DIRECT) begin
      w_state_nxt = DIRECT;
      w_cnt_nxt   = '0;
      if (bus.load) begin
        w_idx_nxt = bus.d;
      end
    end else begin
      w_state_nxt = SCAN;
      case (r_state)
        SCAN: begin
          if (bus.load) begin
            w_idx_nxt = bus.d;
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = r_idx + 1'b1;
            w_wrap_nxt = (r_idx == '1);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          // Scan entry restarts from d when loading, otherwise from line 0.
          w_idx_nxt = bus.load ? bus.d : '0;
          w_cnt_nxt = '0;
        end
      endcase
    end

    w_y_nxt = (w_state_nxt == IDLE) ? Y_INACTIVE : w_dec;
  end

  assign bus.y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: four scan_decoder configurations share one stimulus stream
// and are compared each cycle against an elapsed-time reference model.
module tb_scan_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(2)) if0 ();
  scan_decoder_if #(.SEL_W(2)) if1 ();
  scan_decoder_if #(.SEL_W(2)) if2 ();
  scan_decoder_if #(.SEL_W(3)) if3 ();

  scan_decoder #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  scan_decoder #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  scan_decoder #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int checks   = 0;
  int failures = 0;

  logic       t_en, t_mode, t_load;
  logic [2:0] t_d;

  // Reference model: 0=idle 1=direct 2=scan; scan index derived from time since start.
  int m_sw [4] = '{2, 2, 2, 3};
  int m_dw [4] = '{4, 4, 1, 4};
  int m_al [4] = '{0, 1, 0, 0};
  int m_st [4];
  int m_idx[4];
  int m_base[4];
  int m_el [4];
  int m_wrap[4];

  task automatic drive();
    if0.en = t_en; if0.mode = t_mode; if0.load = t_load; if0.d = t_d[1:0];
    if1.en = t_en; if1.mode = t_mode; if1.load = t_load; if1.d = t_d[1:0];
    if2.en = t_en; if2.mode = t_mode; if2.load = t_load; if2.d = t_d[1:0];
    if3.en = t_en; if3.mode = t_mode; if3.load = t_load; if3.d = t_d;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int n;
      int dv;
      n  = 1 << m_sw[k];
      dv = int'(t_d) % n;
      m_wrap[k] = 0;
      if (rst) begin
        m_st[k] = 0; m_idx[k] = 0; m_el[k] = 0; m_base[k] = 0;
      end else if (!t_en) begin
        m_st[k] = 0;
      end else if (!t_mode) begin
        m_st[k] = 1;
        if (t_load) m_idx[k] = dv;
      end else begin
        if (m_st[k] != 2 || t_load) begin
          m_base[k] = t_load ? dv : 0;
          m_el[k]   = 0;
        end else begin
          m_el[k] = m_el[k] + 1;
        end
        m_idx[k]  = (m_base[k] + m_el[k] / m_dw[k]) % n;
        m_wrap[k] = (m_el[k] > 0 && (m_el[k] % m_dw[k]) == 0 && m_idx[k] == 0) ? 1 : 0;
        m_st[k]   = 2;
      end
    end
  endtask

  function automatic int exp_y(int k);
    int all_ones;
    int oh;
    all_ones = (1 << (1 << m_sw[k])) - 1;
    oh = (m_st[k] == 0) ? 0 : (1 << m_idx[k]);
    return (m_al[k] != 0) ? (all_ones ^ oh) : oh;
  endfunction

  task automatic check(input string tag, input int k, input logic [7:0] obs, input int expv);
    logic [7:0] e;
    e = 8'(expv);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, e);
    end
  endtask

  task automatic check_all();
    check("y",    0, 8'(if0.y),    exp_y(0));
    check("idx",  0, 8'(if0.idx),  m_idx[0]);
    check("wrap", 0, 8'(if0.wrap), m_wrap[0]);
    check("y",    1, 8'(if1.y),    exp_y(1));
    check("idx",  1, 8'(if1.idx),  m_idx[1]);
    check("wrap", 1, 8'(if1.wrap), m_wrap[1]);
    check("y",    2, 8'(if2.y),    exp_y(2));
    check("idx",  2, 8'(if2.idx),  m_idx[2]);
    check("wrap", 2, 8'(if2.wrap), m_wrap[2]);
    check("y",    3, 8'(if3.y),    exp_y(3));
    check("idx",  3, 8'(if3.idx),  m_idx[3]);
    check("wrap", 3, 8'(if3.wrap), m_wrap[3]);
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_base[k] = 0; m_el[k] = 0; m_wrap[k] = 0;
    end

    // Reset held two cycles with scan requested
    rst = 1'b1; t_en = 1'b1; t_mode = 1'b1; t_load = 1'b0; t_d = 3'd0;
    step();
    step();
    check("rst_y0",    0, 8'(if0.y),    8'h00);
    check("rst_y1",    1, 8'(if1.y),    8'h0f);
    check("rst_idx0",  0, 8'(if0.idx),  8'h00);
    check("rst_wrap0", 0, 8'(if0.wrap), 8'h00);

    // Scan timing: 20 cycles
    rst = 1'b0;
    step();
    check("scan_entry_y0", 0, 8'(if0.y), 8'h01);
    for (int c = 1; c < 20; c++) step();

    // Direct sweep d=0..3
    t_mode = 1'b0;
    for (int v = 0; v < 4; v++) begin
      t_load = 1'b1; t_d = 3'(v);
      step();
    end
    check("dir_y0", 0, 8'(if0.y), 8'h08);
    check("dir_y1", 1, 8'(if1.y), 8'h07);
    t_load = 1'b0;
    step();
    check("dir_hold_idx0", 0, 8'(if0.idx), 8'h03);

    // Scan load with DWELL=1
    t_mode = 1'b1;
    step(); step(); step();
    t_load = 1'b1; t_d = 3'd2;
    step();
    check("d1_load_y2", 2, 8'(if2.y), 8'h04);
    t_load = 1'b0;
    step();
    check("d1_next_y2", 2, 8'(if2.y), 8'h08);
    step();
    check("d1_wrap_y2",  2, 8'(if2.y),    8'h01);
    check("d1_wrap_bit", 2, 8'(if2.wrap), 8'h01);

    // Disable mid-scan, then en=0 with load
    step(); step();
    t_en = 1'b0;
    step();
    check("dis_y0", 0, 8'(if0.y), 8'h00);
    t_load = 1'b1; t_d = 3'd3;
    step();
    check("dis_load_y0", 0, 8'(if0.y), 8'h00);
    t_load = 1'b0;
    step();

    // Mid-scan reset at idx=7 on the would-be wrap cycle
    t_en = 1'b1; t_mode = 1'b1; t_load = 1'b1; t_d = 3'd7;
    step();
    check("pre_rst_idx3", 3, 8'(if3.idx), 8'h07);
    t_load = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_wrap3", 3, 8'(if3.wrap), 8'h00);
    check("mid_rst_y3",    3, 8'(if3.y),    8'h00);
    check("mid_rst_idx3",  3, 8'(if3.idx),  8'h00);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 39) == 0);
      t_en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) t_mode = ~t_mode;
      t_load = ($urandom_range(0, 5) == 0);
      t_d    = 3'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
